// File: rtl/mem_pkg.sv
// Shared definitions for the boot memory subsystem: loader states, vector map
// and address-range decode.
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_L  = 3'd1,
        ST_ADDR_H  = 3'd2,
        ST_DATA    = 3'd3,
        ST_VEC     = 3'd4,
        ST_RELEASE = 3'd5,
        ST_RUN     = 3'd6
    } ld_state_e;

    localparam logic [15:0] NMI_LSB   = 16'hFFFA;
    localparam logic [15:0] RESET_LSB = 16'hFFFC;
    localparam logic [15:0] IRQ_LSB   = 16'hFFFE;

    localparam int unsigned VEC_BYTES = 6;
    localparam logic [2:0]  VEC_RST_L = 3'(RESET_LSB - NMI_LSB);
    localparam logic [2:0]  VEC_RST_H = 3'(RESET_LSB - NMI_LSB + 16'd1);

    function automatic logic is_ram(input logic [15:0] addr, input int unsigned aw);
        return (32'(addr) >> aw) == 32'd0;
    endfunction

    function automatic logic is_vec(input logic [15:0] addr);
        return addr >= NMI_LSB;
    endfunction

    // Vector register index: 0xFFFA -> 0 ... 0xFFFF -> 5.
    function automatic logic [2:0] vec_idx(input logic [15:0] addr);
        return 3'(addr[2:0] - NMI_LSB[2:0]);
    endfunction

endpackage

// File: rtl/sys_ram.sv
// Single-port-write RAM with asynchronous read; contents are never cleared.
module sys_ram #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/boot_mem.sv
// 6502 memory subsystem: RAM + vector registers on the core bus, and a
// byte-stream program loader that owns the core reset.
module boot_mem
    import mem_pkg::*;
#(
    parameter int unsigned RAM_AW          = 11,
    parameter int unsigned RESET_HOLD      = 4,
    parameter logic [7:0]  UNMAPPED_DATA   = 8'hFF,
    parameter logic [15:0] RST_VEC_DEFAULT = 16'h0200
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] core_address,
    input  logic [7:0]  core_wr_data,
    input  logic        core_wr_enable,
    output logic [7:0]  core_rd_data,
    output logic        core_resetn,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic        ld_err
);

    localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);

    ld_state_e          r_state;
    logic [15:0]        r_load_ptr;
    logic [15:0]        r_start;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_core_resetn;
    logic               r_err;
    logic [7:0]         r_vec [VEC_BYTES];

    logic               w_accept;
    logic               w_ld_wr;
    logic               w_core_wr;
    logic               w_wr_en;
    logic [15:0]        w_wr_addr;
    logic [7:0]         w_wr_data;
    logic               w_ram_we;
    logic               w_vec_we;
    logic [7:0]         w_ram_rd;

    assign ld_ready = ((r_state == ST_ADDR_L) || (r_state == ST_ADDR_H) ||
                       (r_state == ST_DATA)) && !ld_start;
    assign ld_busy  = (r_state != ST_IDLE) && (r_state != ST_RUN);
    assign ld_err      = r_err;
    assign core_resetn = r_core_resetn;

    // Shared write port: loader payload in DATA, core bus in RUN; ld_start aborts both.
    assign w_accept  = ld_valid && ld_ready;
    assign w_ld_wr   = w_accept && (r_state == ST_DATA);
    assign w_core_wr = core_wr_enable && (r_state == ST_RUN) && !ld_start;
    assign w_wr_en   = w_ld_wr || w_core_wr;
    assign w_wr_addr = w_ld_wr ? r_load_ptr : core_address;
    assign w_wr_data = w_ld_wr ? ld_data : core_wr_data;
    assign w_ram_we  = w_wr_en && is_ram(w_wr_addr, RAM_AW);
    assign w_vec_we  = w_wr_en && !is_ram(w_wr_addr, RAM_AW) && is_vec(w_wr_addr);

    sys_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_wr_addr[RAM_AW-1:0]),
        .i_wdata (w_wr_data),
        .i_raddr (core_address[RAM_AW-1:0]),
        .o_rdata (w_ram_rd)
    );

    always_comb begin
        core_rd_data = UNMAPPED_DATA;
        if (is_ram(core_address, RAM_AW)) begin
            core_rd_data = w_ram_rd;
        end else if (is_vec(core_address)) begin
            core_rd_data = r_vec[vec_idx(core_address)];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_load_ptr    <= 16'h0000;
            r_start       <= 16'h0000;
            r_hold        <= '0;
            r_core_resetn <= 1'b0;
            r_err         <= 1'b0;
            for (int i = 0; i < VEC_BYTES; i++) begin
                r_vec[i] <= 8'h00;
            end
            r_vec[VEC_RST_L] <= RST_VEC_DEFAULT[7:0];
            r_vec[VEC_RST_H] <= RST_VEC_DEFAULT[15:8];
        end else if (ld_start) begin
            r_state       <= ST_ADDR_L;
            r_hold        <= '0;
            r_core_resetn <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (w_vec_we) begin
                r_vec[vec_idx(w_wr_addr)] <= w_wr_data;
            end
            case (r_state)
                ST_ADDR_L: begin
                    if (w_accept) begin
                        r_load_ptr[7:0] <= ld_data;
                        r_start[7:0]    <= ld_data;
                        r_state         <= ST_ADDR_H;
                    end
                end
                ST_ADDR_H: begin
                    if (w_accept) begin
                        r_load_ptr[15:8] <= ld_data;
                        r_start[15:8]    <= ld_data;
                        r_state          <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_load_ptr <= r_load_ptr + 16'd1;
                        if (!is_ram(r_load_ptr, RAM_AW) && !is_vec(r_load_ptr)) begin
                            r_err <= 1'b1;
                        end
                        if (ld_last) begin
                            r_state <= ST_VEC;
                        end
                    end
                end
                ST_VEC: begin
                    r_vec[VEC_RST_L] <= r_start[7:0];
                    r_vec[VEC_RST_H] <= r_start[15:8];
                    r_hold           <= '0;
                    r_state          <= ST_RELEASE;
                end
                // Core reset rises together with the entry to RUN.
                ST_RELEASE: begin
                    if (r_hold == HOLD_W'(RESET_HOLD)) begin
                        r_state       <= ST_RUN;
                        r_core_resetn <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                ST_IDLE, ST_RUN: begin
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_mem.sv
// Directed self-checking bench for boot_mem: reset map, loads, wrap,
// unmapped loads, core writes, abort and mid-load reset.
module tb_boot_mem;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] core_address = 16'h0000;
    logic [7:0]  core_wr_data = 8'h00;
    logic        core_wr_enable = 1'b0;
    logic [7:0]  core_rd_data;
    logic        core_resetn;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_err;

    int checks = 0;
    int errors = 0;
    int cnt;
    logic [7:0] pay [0:7];

    always #5 clk = ~clk;

    boot_mem dut (
        .clk            (clk),
        .resetn         (resetn),
        .core_address   (core_address),
        .core_wr_data   (core_wr_data),
        .core_wr_enable (core_wr_enable),
        .core_rd_data   (core_rd_data),
        .core_resetn    (core_resetn),
        .ld_start       (ld_start),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .ld_ready       (ld_ready),
        .ld_busy        (ld_busy),
        .ld_err         (ld_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(negedge clk);
        ld_start = 1'b1;
        ld_valid = 1'b0;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    // Called at a negedge; the byte is presented across the next posedge.
    task automatic send(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic load_image(input logic [15:0] addr, input int n);
        do_start();
        send(addr[7:0], 1'b0);
        send(addr[15:8], 1'b0);
        for (int i = 0; i < n; i++) send(pay[i], i == n - 1);
    endtask

    // Negedges from now until core_resetn is high, capped at 20.
    task automatic wait_run();
        cnt = 0;
        while (!core_resetn && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic core_write(input logic [15:0] a, input logic [7:0] d);
        core_address   = a;
        core_wr_data   = d;
        core_wr_enable = 1'b1;
        @(negedge clk);
        core_wr_enable = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        core_address = 16'hFFFC; #1;
        checks++; if (core_rd_data !== 8'h00) begin errors++; $display("FAIL rst_vec_lo got %h exp 00", core_rd_data); end
        core_address = 16'hFFFD; #1;
        checks++; if (core_rd_data !== 8'h02) begin errors++; $display("FAIL rst_vec_hi got %h exp 02", core_rd_data); end
        core_address = 16'hFFFA; #1;
        checks++; if (core_rd_data !== 8'h00) begin errors++; $display("FAIL rst_nmi_lo got %h exp 00", core_rd_data); end
        core_address = 16'h1234; #1;
        checks++; if (core_rd_data !== 8'hFF) begin errors++; $display("FAIL rst_unmapped got %h exp FF", core_rd_data); end
        checks++; if (core_resetn !== 1'b0) begin errors++; $display("FAIL rst_core_resetn got %b exp 0", core_resetn); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ld_ready); end
        checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", ld_busy); end
        checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", ld_err); end
    endtask

    task automatic test_basic_load();
        pay[0] = 8'hA9; pay[1] = 8'h05; pay[2] = 8'hEA;
        load_image(16'h0200, 3);
        checks++; if (ld_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", ld_busy); end
        wait_run();
        checks++; if (cnt !== 6) begin errors++; $display("FAIL basic_release_latency got %0d exp 6", cnt); end
        core_address = 16'h0200; #1;
        checks++; if (core_rd_data !== 8'hA9) begin errors++; $display("FAIL basic_ram0 got %h exp A9", core_rd_data); end
        core_address = 16'h0201; #1;
        checks++; if (core_rd_data !== 8'h05) begin errors++; $display("FAIL basic_ram1 got %h exp 05", core_rd_data); end
        core_address = 16'h0202; #1;
        checks++; if (core_rd_data !== 8'hEA) begin errors++; $display("FAIL basic_ram2 got %h exp EA", core_rd_data); end
        core_address = 16'hFFFD; #1;
        checks++; if (core_rd_data !== 8'h02) begin errors++; $display("FAIL basic_vec_hi got %h exp 02", core_rd_data); end
        checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_run got %b exp 0", ld_busy); end
    endtask

    task automatic test_wrap();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        load_image(16'hFFFE, 3);
        wait_run();
        checks++; if (cnt !== 6) begin errors++; $display("FAIL wrap_latency got %0d exp 6", cnt); end
        core_address = 16'hFFFE; #1;
        checks++; if (core_rd_data !== 8'h11) begin errors++; $display("FAIL wrap_fffe got %h exp 11", core_rd_data); end
        core_address = 16'hFFFF; #1;
        checks++; if (core_rd_data !== 8'h22) begin errors++; $display("FAIL wrap_ffff got %h exp 22", core_rd_data); end
        core_address = 16'h0000; #1;
        checks++; if (core_rd_data !== 8'h33) begin errors++; $display("FAIL wrap_0000 got %h exp 33", core_rd_data); end
        core_address = 16'hFFFC; #1;
        checks++; if (core_rd_data !== 8'hFE) begin errors++; $display("FAIL wrap_vec_lo got %h exp FE", core_rd_data); end
        core_address = 16'hFFFD; #1;
        checks++; if (core_rd_data !== 8'hFF) begin errors++; $display("FAIL wrap_vec_hi got %h exp FF", core_rd_data); end
        checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", ld_err); end
    endtask

    task automatic test_unmapped();
        pay[0] = 8'h01; pay[1] = 8'h02;
        load_image(16'h4000, 2);
        checks++; if (ld_err !== 1'b1) begin errors++; $display("FAIL unmapped_err got %b exp 1", ld_err); end
        core_address = 16'h4000; #1;
        checks++; if (core_rd_data !== 8'hFF) begin errors++; $display("FAIL unmapped_read got %h exp FF", core_rd_data); end
        do_start();
        checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL unmapped_err_clear got %b exp 0", ld_err); end
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h60, 1'b1);
        wait_run();
        core_address = 16'h0300; #1;
        checks++; if (core_rd_data !== 8'h60) begin errors++; $display("FAIL reload_ram got %h exp 60", core_rd_data); end
        core_address = 16'hFFFD; #1;
        checks++; if (core_rd_data !== 8'h03) begin errors++; $display("FAIL reload_vec_hi got %h exp 03", core_rd_data); end
    endtask

    task automatic test_core_write();
        core_write(16'h0010, 8'h5A);
        core_address = 16'h0010; #1;
        checks++; if (core_rd_data !== 8'h5A) begin errors++; $display("FAIL core_wr_ram got %h exp 5A", core_rd_data); end
        core_write(16'h8000, 8'h77);
        core_address = 16'h8000; #1;
        checks++; if (core_rd_data !== 8'hFF) begin errors++; $display("FAIL core_wr_unmapped got %h exp FF", core_rd_data); end
        checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL core_wr_err got %b exp 0", ld_err); end
        core_write(16'hFFFA, 8'hC3);
        core_address = 16'hFFFA; #1;
        checks++; if (core_rd_data !== 8'hC3) begin errors++; $display("FAIL core_wr_vec got %h exp C3", core_rd_data); end
        core_write(16'h0710, 8'h10);
        core_address = 16'h0710; #1;
        checks++; if (core_rd_data !== 8'h10) begin errors++; $display("FAIL core_wr_0710 got %h exp 10", core_rd_data); end
    endtask

    task automatic test_abort();
        do_start();
        checks++; if (core_resetn !== 1'b0) begin errors++; $display("FAIL abort_run_resetn got %b exp 0", core_resetn); end
        core_write(16'h0710, 8'h55);
        core_address = 16'h0710; #1;
        checks++; if (core_rd_data !== 8'h10) begin errors++; $display("FAIL core_wr_outside_run got %h exp 10", core_rd_data); end
        send(8'h00, 1'b0);
        send(8'h05, 1'b0);
        send(8'h11, 1'b0);
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h99; #1;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", ld_ready); end
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b0;
        checks++; if (ld_busy !== 1'b1 || core_resetn !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b resetn=%b exp busy=1 resetn=0", ld_busy, core_resetn); end
        send(8'h00, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (ld_busy !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("FAIL idle_valid_low got busy=%b ready=%b exp 1 1", ld_busy, ld_ready); end
        send(8'h06, 1'b0);
        send(8'h42, 1'b1);
        wait_run();
        checks++; if (cnt !== 6) begin errors++; $display("FAIL abort_latency got %0d exp 6", cnt); end
        core_address = 16'h0600; #1;
        checks++; if (core_rd_data !== 8'h42) begin errors++; $display("FAIL abort_ram got %h exp 42", core_rd_data); end
        core_address = 16'hFFFD; #1;
        checks++; if (core_rd_data !== 8'h06) begin errors++; $display("FAIL abort_vec_hi got %h exp 06", core_rd_data); end
    endtask

    task automatic test_reset_midload();
        do_start();
        send(8'h00, 1'b0);
        send(8'h07, 1'b0);
        send(8'h31, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (core_resetn !== 1'b0 || ld_busy !== 1'b0) begin errors++; $display("FAIL midreset_state got resetn=%b busy=%b exp 0 0", core_resetn, ld_busy); end
        core_address = 16'h0700; #1;
        checks++; if (core_rd_data !== 8'h31) begin errors++; $display("FAIL midreset_ram_kept got %h exp 31", core_rd_data); end
        core_address = 16'hFFFD; #1;
        checks++; if (core_rd_data !== 8'h02) begin errors++; $display("FAIL midreset_vec got %h exp 02", core_rd_data); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_wrap();
        test_unmapped();
        test_core_write();
        test_abort();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_mem.md
# boot_mem

Memory subsystem and program loader for the 6502 core:
- Services the core bus (`address`, `wr_data`, `wr_enable` → `rd_data`) from an on-chip RAM and a six-byte vector register file.
- Owns the core's reset: holds it low while a host streams a program image in over a valid/ready byte interface.
- After loading, writes the reset vector to point at the load address, then releases the core.

## Interface
Parameters:
- `RAM_AW`, 11, RAM address width; RAM maps `0x0000`–`2^RAM_AW-1`
- `RESET_HOLD`, 4, cycles `core_resetn` stays low after the vector write (≥1)
- `UNMAPPED_DATA`, 8'hFF, read value for unmapped addresses
- `RST_VEC_DEFAULT`, 16'h0200, reset-vector value after `resetn`

Ports:
- `clk` in 1 — clock
- `resetn` in 1 — reset, synchronous, active-low
- `core_address` in 16 — core bus address (registered by the core)
- `core_wr_data` in 8 — core write data
- `core_wr_enable` in 1 — core write strobe
- `core_rd_data` out 8 — read data, combinational from `core_address`
- `core_resetn` out 1 — registered reset to the core
- `ld_start` in 1 — pulse; aborts any activity and begins a new load
- `ld_valid` in 1 — host byte valid
- `ld_data` in 8 — host byte
- `ld_last` in 1 — marks the final payload byte
- `ld_ready` out 1 — loader accepts a byte this cycle
- `ld_busy` out 1 — state is not IDLE and not RUN
- `ld_err` out 1 — sticky flag; a payload byte targeted an unmapped address

## Operation
- **States:** IDLE, ADDR_L, ADDR_H, DATA, VEC, RELEASE, RUN.
- **Reset values:**
  - State IDLE; `core_resetn`=0; `ld_ready`=0; `ld_busy`=0; `ld_err`=0.
  - Vectors `0xFFFA`/`0xFFFB`/`0xFFFE`/`0xFFFF` = 0x00; `0xFFFC`/`0xFFFD` = `RST_VEC_DEFAULT`.
  - RAM contents are not cleared.
- **`ld_start`** (any state, highest priority):
  - Next state ADDR_L; `core_resetn`←0; `ld_err`←0; hold counter cleared.
  - `ld_ready` is forced 0 in that cycle, so no byte is accepted.
- **Byte acceptance:** a byte is accepted on any edge with `ld_valid`&`ld_ready`. `ld_ready` = (state ∈ {ADDR_L, ADDR_H, DATA}) & !`ld_start`.
- **ADDR_L:** accepted byte → `load_ptr[7:0]` and `start[7:0]`; next ADDR_H.
- **ADDR_H:** accepted byte → `load_ptr[15:8]` and `start[15:8]`; next DATA. `ld_last` is ignored in both ADDR states.
- **DATA:** each accepted byte is written to `load_ptr`, then `load_ptr`+1.
  - `load_ptr` wraps mod 2^16 (`0xFFFF`→`0x0000`).
  - An accepted byte with `ld_last`=1 is written, then next state is VEC.
- **Loader writes by address:**
  - RAM range: written to RAM.
  - `0xFFFA`–`0xFFFF`: written to the vector register.
  - Otherwise: dropped, and `ld_err`←1.
- **VEC:** one cycle; `0xFFFC`←`start[7:0]`, `0xFFFD`←`start[15:8]`; next RELEASE. This overrides any payload write to the same addresses.
- **RELEASE:** counts `RESET_HOLD` cycles, then RUN.
- **RUN:** `core_resetn`=1. Core writes with `core_wr_enable`=1 are applied at the edge, mapped as for the loader; unmapped core writes are silently dropped and do not set `ld_err`.
- **Core writes outside RUN** are ignored.
- **Reads** are valid in all states: RAM, vector register, or `UNMAPPED_DATA`.
- **`resetn` mid-load:** returns to IDLE; partial RAM contents are retained; the core stays in reset until the next complete load.

## Timing
- Core read: zero latency; `core_rd_data` settles in the same cycle `core_address` changes. This supports the core's one-cycle address-to-sample pipeline.
- Core write: visible to a read of the same address on the next cycle.
- Loader write: committed on the accepting edge.
- From the edge accepting `ld_last` to `core_resetn`=1: 1 (VEC) + `RESET_HOLD` + 1 edges. Default = 6 cycles.
- Minimum load of N payload bytes at full throughput: N+2 accepting cycles.
- `ld_start` in RUN: `core_resetn` falls on the same edge that enters ADDR_L.

## Structure
- Package `mem_pkg` holds:
  - the loader state enum;
  - vector address constants `NMI_LSB`=`0xFFFA`, `RESET_LSB`=`0xFFFC`, `IRQ_LSB`=`0xFFFE`;
  - address-range decode function `is_ram` / `is_vec`.
- Sub-module `sys_ram`: a 2^`RAM_AW` × 8 array with asynchronous read and one synchronous write port. The write-port mux (loader vs. core) stays in `boot_mem`.

## Test plan
- Reset, then read `0xFFFC`/`0xFFFD` → 0x00/0x02. Read `0x1234` → 0xFF. `core_resetn`=0.
- `ld_start`, then bytes 0x00, 0x02, A9, 05, EA (last) → RAM[`0x0200`..`0x0202`]=A9, 05, EA; vector=`0x0200`; `core_resetn` rises exactly 6 cycles after the `ld_last` edge.
- Load at start `0xFFFE` with 3 bytes → `0xFFFE`=b0, `0xFFFF`=b1, `0x0000`=b2 (wrap); vector=`0xFFFE`; `ld_err`=0.
- Load at start `0x4000` → bytes dropped, `ld_err`=1; a following `ld_start` clears it.
- In RUN: core writes 0x5A to `0x0010` → next-cycle read 0x5A. A core write to `0x8000` changes nothing and leaves `ld_err` unchanged.
- `ld_start` asserted with `ld_valid` during DATA → byte not accepted, state ADDR_L, `core_resetn`=0. `ld_valid` held low for 10 cycles → no state change.
